// File: rtl/rle_decoder_if.sv
// Single-port dpsram port A bundle shared by the RLE decoder for both reads and writes.
// The decoder drives address/data/we/clock; the memory returns read data two edges after the address.
interface rle_decoder_if;
    logic        port_A_clk;
    logic [15:0] port_A_addr;
    logic [31:0] port_A_data_in;
    logic [31:0] port_A_data_out;
    logic        port_A_we;

    modport master (
        output port_A_clk,
        output port_A_addr,
        output port_A_data_in,
        output port_A_we,
        input  port_A_data_out
    );

    modport slave (
        input  port_A_clk,
        input  port_A_addr,
        input  port_A_data_in,
        input  port_A_we,
        output port_A_data_out
    );
endinterface

// File: rtl/rle_decoder.sv
// Run-length decoder: expands (symbol,count) byte pairs read from dpsram into packed plaintext words,
// written back through the same port A, with an output byte cap that aborts the frame with error.
module rle_decoder #(
    parameter logic [31:0] MAX_OUT_BYTES = 32'd65536
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [31:0]   rle_addr,
    input  logic [31:0]   rle_size,
    input  logic [31:0]   message_addr,
    output logic [31:0]   message_size,
    output logic          done,
    output logic          error,
    rle_decoder_if.master mem
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_ADDR, S_RD_WAIT, S_RD_LATCH, S_PAIR,
        S_EMIT, S_WR, S_NEXT, S_FLUSH, S_DONE
    } state_t;

    state_t      r_state, w_next;

    logic [31:0] r_rle_base, r_msg_base, r_rd_off, r_wr_off;
    logic [31:0] r_pairs_left, r_count, r_msg_size;
    logic [31:0] r_word, r_acc;
    logic [7:0]  r_sym, r_cnt;
    logic [1:0]  r_lane;
    logic        r_pair_sel;
    logic        r_done, r_err;

    logic [31:0] w_rd_ptr, w_wr_ptr, w_count_inc;
    logic [7:0]  w_pair_sym, w_pair_cnt, w_cnt_dec;
    logic [15:0] w_addr;
    logic [31:0] w_din;
    logic        w_we, w_ovf;
    logic        w_unused_hi;

    assign w_rd_ptr    = r_rle_base + r_rd_off;
    assign w_wr_ptr    = r_msg_base + r_wr_off;
    assign w_count_inc = r_count + 32'd1;
    assign w_cnt_dec   = r_cnt - 8'd1;
    assign w_pair_sym  = r_pair_sel ? r_word[31:24] : r_word[15:8];
    assign w_pair_cnt  = r_pair_sel ? r_word[23:16] : r_word[7:0];
    // dpsram is 64 KB; pointer high bits are deliberately dropped so addresses wrap
    assign w_unused_hi = ^{w_rd_ptr[31:16], w_wr_ptr[31:16]};

    assign mem.port_A_clk     = clk;
    assign mem.port_A_addr    = w_addr;
    assign mem.port_A_data_in = w_din;
    assign mem.port_A_we      = w_we;

    assign message_size = r_msg_size;
    assign done         = r_done;
    assign error        = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_ovf  = 1'b0;
        w_addr = 16'd0;
        w_din  = 32'd0;
        w_we   = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = (rle_size < 32'd2) ? S_DONE : S_RD_ADDR;
            S_RD_ADDR: begin
                w_addr = w_rd_ptr[15:0];
                w_next = S_RD_WAIT;
            end
            S_RD_WAIT:  w_next = S_RD_LATCH;
            S_RD_LATCH: w_next = S_PAIR;
            S_PAIR: begin
                if (w_pair_cnt == 8'd0)               w_next = S_NEXT;
                else if (r_count == MAX_OUT_BYTES) begin
                    w_ovf  = 1'b1;
                    w_next = S_FLUSH;
                end else                              w_next = S_EMIT;
            end
            S_EMIT: begin
                // a full word takes priority; WR re-checks count/cap afterwards
                if (r_lane == 2'd3)                   w_next = S_WR;
                else if (w_cnt_dec == 8'd0)           w_next = S_NEXT;
                else if (w_count_inc == MAX_OUT_BYTES) begin
                    w_ovf  = 1'b1;
                    w_next = S_FLUSH;
                end
            end
            S_WR: begin
                w_addr = w_wr_ptr[15:0];
                w_din  = r_acc;
                w_we   = 1'b1;
                if (r_cnt == 8'd0)                    w_next = S_NEXT;
                else if (r_count == MAX_OUT_BYTES) begin
                    w_ovf  = 1'b1;
                    w_next = S_FLUSH;
                end else                              w_next = S_EMIT;
            end
            S_NEXT: begin
                if (r_pairs_left == 32'd0) w_next = S_FLUSH;
                else if (!r_pair_sel)      w_next = S_PAIR;
                else                       w_next = S_RD_ADDR;
            end
            S_FLUSH: begin
                if (r_lane != 2'd0) begin
                    w_addr = w_wr_ptr[15:0];
                    w_din  = r_acc;
                    w_we   = 1'b1;
                end
                w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rle_base   <= 32'd0;
            r_msg_base   <= 32'd0;
            r_rd_off     <= 32'd0;
            r_wr_off     <= 32'd0;
            r_pairs_left <= 32'd0;
            r_count      <= 32'd0;
            r_msg_size   <= 32'd0;
            r_word       <= 32'd0;
            r_acc        <= 32'd0;
            r_sym        <= 8'd0;
            r_cnt        <= 8'd0;
            r_lane       <= 2'd0;
            r_pair_sel   <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_ovf) r_err <= 1'b1;
            case (r_state)
                S_IDLE: if (start) begin
                    r_rle_base   <= rle_addr;
                    r_msg_base   <= message_addr;
                    r_rd_off     <= 32'd0;
                    r_wr_off     <= 32'd0;
                    r_pairs_left <= {1'b0, rle_size[31:1]};
                    r_count      <= 32'd0;
                    r_acc        <= 32'd0;
                    r_lane       <= 2'd0;
                    r_pair_sel   <= 1'b0;
                    r_done       <= 1'b0;
                    r_err        <= rle_size[0];
                end
                S_RD_LATCH: begin
                    r_word     <= mem.port_A_data_out;
                    r_rd_off   <= r_rd_off + 32'd4;
                    r_pair_sel <= 1'b0;
                end
                S_PAIR: begin
                    r_sym        <= w_pair_sym;
                    r_cnt        <= w_pair_cnt;
                    r_pairs_left <= r_pairs_left - 32'd1;
                end
                S_EMIT: begin
                    r_acc[{r_lane, 3'b000} +: 8] <= r_sym;
                    r_cnt   <= w_cnt_dec;
                    r_count <= w_count_inc;
                    r_lane  <= r_lane + 2'd1;
                end
                S_WR: begin
                    r_wr_off <= r_wr_off + 32'd4;
                    r_acc    <= 32'd0;
                    r_lane   <= 2'd0;
                end
                S_NEXT: if (r_pairs_left != 32'd0 && !r_pair_sel) r_pair_sel <= 1'b1;
                S_DONE: begin
                    r_done     <= 1'b1;
                    r_msg_size <= r_count;
                end
                default: ;
            endcase
        end
    end

endmodule
